// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state
// encoding, instruction field constants, ALU operation classes and ALU
// control codes.
package mips_pkg;

    // Controller states; RESET must stay at encoding zero.
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    // Opcode field values (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field values (instr[5:0]).
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU operation class handed from the FSM to the ALU decoder.
    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALU_OP_ADD   = 2'b00;
    localparam alu_op_t ALU_OP_SUB   = 2'b01;
    localparam alu_op_t ALU_OP_FUNCT = 2'b10;

    // ALU control codes.
    localparam logic [2:0] ALU_CTL_AND = 3'b000;
    localparam logic [2:0] ALU_CTL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTL_SLT = 3'b111;

    // True for every opcode the controller knows how to execute.
    function automatic logic is_supported_op(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: maps the FSM's ALU operation class
// and, for R-type instructions, the funct field to an ALU control code.
module alu_decoder
    import mips_pkg::*;
#(
    parameter int FUNCT_WIDTH = 6
) (
    input  logic [1:0]             alu_op,
    input  logic [FUNCT_WIDTH-1:0] funct,
    output logic [2:0]             alu_control
);

    // Decode operation class first, then funct for the R-type class.
    always_comb begin
        alu_control = ALU_CTL_AND;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_CTL_ADD;
            ALU_OP_SUB: alu_control = ALU_CTL_SUB;
            default: begin
                // alu_op 1x: R-type, operation chosen by funct
                case (funct)
                    FUNCT_ADD: alu_control = ALU_CTL_ADD;
                    FUNCT_SUB: alu_control = ALU_CTL_SUB;
                    FUNCT_AND: alu_control = ALU_CTL_AND;
                    FUNCT_OR:  alu_control = ALU_CTL_OR;
                    FUNCT_SLT: alu_control = ALU_CTL_SLT;
                    default:   alu_control = ALU_CTL_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/main_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode and
// the per-class execute/writeback steps, plus the PC enable combining the
// unconditional PC write with a taken branch.
module main_controller
    import mips_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    input  logic                    zero,
    output logic                    pc_en,
    output logic                    iord,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              pc_src,
    output logic [2:0]              alu_control,
    output logic                    illegal_op,
    output logic [3:0]              state
);

    state_t  state_q;
    state_t  state_d;
    logic    pc_write_s;
    logic    branch_s;
    alu_op_t alu_op_s;
    logic [2:0] alu_ctl_s;

    // State register with synchronous reset that wins from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEMADR.
    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // A non-memory opcode here means a corrupted instruction: abandon it.
                if (opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_RESET;
        endcase
    end

    // Moore output decode; every control defaults to inactive.
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write_s = 1'b0;
        branch_s   = 1'b0;
        alu_op_s   = ALU_OP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~is_supported_op(opcode);
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op_s  = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op_s  = ALU_OP_SUB;
                pc_src    = 2'b01;
                branch_s  = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write_s = 1'b1;
            end
            default: begin
                alu_op_s = ALU_OP_ADD;
            end
        endcase
    end

    alu_decoder #(
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_alu_decoder (
        .alu_op      (alu_op_s),
        .funct       (funct),
        .alu_control (alu_ctl_s)
    );

    // ALU control is forced to zero in RESET so every output reads idle there.
    always_comb begin
        if (state_q == S_RESET) begin
            alu_control = 3'b000;
        end else begin
            alu_control = alu_ctl_s;
        end
    end

    // PC enable follows zero combinationally so a taken branch loads this cycle.
    always_comb begin
        pc_en = pc_write_s | (branch_s & zero);
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_controller.sv
// Randomized scoreboard bench for main_controller. The stimulus process
// walks a plan of states per instruction (derived from the instruction
// class), pushes the expected outputs for each cycle, and a monitor on the
// falling edge pops and compares.
module tb_main_controller;

    localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                   ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXECUTE = 7,
                   ST_ALUWB = 8, ST_BRANCH = 9, ST_ADDIEXEC = 10, ST_ADDIWB = 11,
                   ST_JUMP = 12;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam int NCYC = 700;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic [3:0] state;

    main_controller #(.OPCODE_WIDTH(6), .FUNCT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [2:0] alu_control;
        logic       illegal_op;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         z;
        int         rst_at;
    } inst_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   mon_cyc = 0;

    function automatic logic [2:0] ref_alu(input int aop, input logic [5:0] fn);
        if (aop == 0) return 3'b010;
        if (aop == 1) return 3'b110;
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle, straight from the per-state table.
    function automatic obs_t ref_out(input int st, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z);
        obs_t o;
        logic pcw, br;
        int   aop;
        o = '0;
        pcw = 1'b0;
        br = 1'b0;
        aop = 0;
        o.state = 4'(st);
        case (st)
            ST_FETCH:    begin o.ir_write = 1'b1; pcw = 1'b1; o.alu_src_b = 2'b01; end
            ST_DECODE:   begin o.alu_src_b = 2'b11;
                               o.illegal_op = !(op inside {LW, SW, RT, BEQ, ADDI, JMP}); end
            ST_MEMADR, ST_ADDIEXEC: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            ST_MEMREAD:  o.iord = 1'b1;
            ST_MEMWB:    begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
            ST_MEMWRITE: begin o.iord = 1'b1; o.mem_write = 1'b1; end
            ST_EXECUTE:  begin o.alu_src_a = 1'b1; aop = 2; end
            ST_ALUWB:    begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
            ST_ADDIWB:   o.reg_write = 1'b1;
            ST_BRANCH:   begin o.alu_src_a = 1'b1; aop = 1; o.pc_src = 2'b01; br = 1'b1; end
            ST_JUMP:     begin o.pc_src = 2'b10; pcw = 1'b1; end
            default:     ;
        endcase
        o.pc_en = pcw | (br & z);
        o.alu_control = (st == ST_RESET) ? 3'b000 : ref_alu(aop, fn);
        return o;
    endfunction

    // Monitor: one output vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.state = state; a.pc_en = pc_en; a.iord = iord; a.mem_write = mem_write;
            a.ir_write = ir_write; a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg;
            a.reg_write = reg_write; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
            a.pc_src = pc_src; a.alu_control = alu_control; a.illegal_op = illegal_op;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d: actual state=%0d vec=%h, required state=%0d vec=%h",
                         mon_cyc, a.state, a, e.state, e);
            end
            mon_cyc++;
        end
    end

    // Stimulus and reference model: each instruction becomes a list of states.
    initial begin
        int         cur, nxt, tmp;
        logic [5:0] i_op, i_fn, op, fn;
        int         i_z, i_rst;
        logic       z, r;
        int         plan[$];
        inst_t      dir[$];
        inst_t      d;

        dir.push_back('{LW,  6'b000000, -1, -1});
        dir.push_back('{RT,  6'b100010, -1, -1});
        dir.push_back('{RT,  6'b101010, -1, -1});
        dir.push_back('{BEQ, 6'b000000,  1, -1});
        dir.push_back('{BEQ, 6'b000000,  0, -1});
        dir.push_back('{6'b111111, 6'b000000, -1, -1});
        dir.push_back('{SW,  6'b000000, -1, ST_MEMWRITE});
        dir.push_back('{ADDI, 6'b000000, -1, -1});
        dir.push_back('{JMP, 6'b000000, -1, -1});
        dir.push_back('{RT,  6'b000111, -1, -1});
        dir.push_back('{RT,  6'b100100, -1, -1});
        dir.push_back('{RT,  6'b100101, -1, -1});
        dir.push_back('{RT,  6'b100000, -1, -1});
        dir.push_back('{SW,  6'b000000, -1, -1});

        i_op = 6'd0; i_fn = 6'd0; i_z = -1; i_rst = -1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cur = ST_RESET;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cur == ST_FETCH) begin
                if (dir.size() > 0) begin
                    d = dir.pop_front();
                    i_op = d.op; i_fn = d.fn; i_z = d.z; i_rst = d.rst_at;
                end else begin
                    tmp = $urandom_range(0, 7);
                    case (tmp)
                        0: i_op = LW;
                        1: i_op = SW;
                        2: i_op = RT;
                        3: i_op = BEQ;
                        4: i_op = ADDI;
                        5: i_op = JMP;
                        default: i_op = 6'($urandom);
                    endcase
                    i_fn = 6'($urandom);
                    if ($urandom_range(0, 1) == 0) i_fn = {3'b100, 3'($urandom_range(0, 5))};
                    i_z = -1; i_rst = -1;
                end
                plan.delete();
                plan.push_back(ST_DECODE);
                case (i_op)
                    LW:   begin plan.push_back(ST_MEMADR); plan.push_back(ST_MEMREAD); plan.push_back(ST_MEMWB); end
                    SW:   begin plan.push_back(ST_MEMADR); plan.push_back(ST_MEMWRITE); end
                    RT:   begin plan.push_back(ST_EXECUTE); plan.push_back(ST_ALUWB); end
                    BEQ:  plan.push_back(ST_BRANCH);
                    ADDI: begin plan.push_back(ST_ADDIEXEC); plan.push_back(ST_ADDIWB); end
                    JMP:  plan.push_back(ST_JUMP);
                    default: ;
                endcase
            end

            // Fields outside the sampling states are scrambled on purpose.
            op = 6'($urandom);
            fn = 6'($urandom);
            z  = 1'($urandom);
            if (cur == ST_DECODE || cur == ST_EXECUTE) begin
                op = i_op; fn = i_fn;
            end else if (cur == ST_MEMADR) begin
                op = i_op;
                if (dir.size() == 0 && $urandom_range(0, 7) == 0) begin
                    op = {2'b00, 4'($urandom)};
                    plan.delete();
                end
            end
            if (cur == ST_BRANCH && i_z >= 0) z = i_z[0];

            r = 1'b0;
            if (cyc == 0) begin
                r = 1'b1;
            end else if (i_rst >= 0 && cur == i_rst) begin
                r = 1'b1;
                i_rst = -1;
            end else if (cyc > 150 && $urandom_range(0, 39) == 0) begin
                r = 1'b1;
            end

            rst = r; opcode = op; funct = fn; zero = z;
            exp_q.push_back(ref_out(cur, op, fn, z));

            if (r) begin
                nxt = ST_RESET;
                plan.delete();
            end else if (cur == ST_RESET || plan.size() == 0) begin
                nxt = ST_FETCH;
            end else begin
                nxt = plan.pop_front();
            end
            @(posedge clk);
            #1;
            cur = nxt;
        end

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 Parameter OPCODE_WIDTH, default 6, width of the instruction opcode field.
REQ-002 Parameter FUNCT_WIDTH, default 6, width of the R-type funct field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 opcode  input  6  instr[31:26] from the instruction register.
REQ-006 funct  input  6  instr[5:0] from the instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 pc_en  output  1  PC register enable.
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write  output  1  memory write enable.
REQ-011 ir_write  output  1  instruction register load.
REQ-012 reg_dst  output  1  register file write address select: 0 = rt, 1 = rd.
REQ-013 mem_to_reg  output  1  register file write data select: 0 = ALUOut, 1 = memory data.
REQ-014 reg_write  output  1  register file write enable; drives WE3.
REQ-015 alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-016 alu_src_b  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-017 pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 alu_control  output  3  ALU operation code.
REQ-019 illegal_op  output  1  unsupported opcode flag.
REQ-020 state  output  4  current state encoding, for debug.

Function
REQ-021 The controller SHALL be a Moore FSM with 13 states: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-022 Transitions SHALL be:
- RESET->FETCH
- FETCH->DECODE
- DECODE->MEMADR (lw 100011 or sw 101011), EXECUTE (R-type 000000), BRANCH (beq 000100), ADDIEXEC (addi 001000), JUMP (j 000010), otherwise FETCH
- MEMADR->MEMREAD (lw) or MEMWRITE (sw)
- MEMREAD->MEMWB
- EXECUTE->ALUWB
- ADDIEXEC->ADDIWB
- MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH
REQ-023 Per-state outputs SHALL be as listed; any signal not listed is 0:
- FETCH: ir_write=1, pc_write=1, alu_src_b=01, alu_op=00
- DECODE: alu_src_b=11, alu_op=00
- MEMADR and ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00
- MEMREAD: iord=1
- MEMWB: mem_to_reg=1, reg_write=1
- MEMWRITE: iord=1, mem_write=1
- EXECUTE: alu_src_a=1, alu_op=10
- ALUWB: reg_dst=1, reg_write=1
- ADDIWB: reg_write=1
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1
- JUMP: pc_src=10, pc_write=1
- RESET: all 0
REQ-024 pc_en SHALL equal pc_write OR (branch AND zero), combinational in zero, with zero-cycle latency.
REQ-025 illegal_op SHALL be 1 only while in DECODE with an unsupported opcode; the next state is then FETCH and no write enable is asserted for that instruction.
REQ-026 MEMADR with an opcode that is neither lw nor sw (not reachable in normal operation) SHALL go to FETCH.
REQ-027 alu_control decoding:
- alu_op 00 -> 010 (add)
- alu_op 01 -> 110 (sub)
- alu_op 1x, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 000
REQ-028 opcode and funct SHALL be sampled only in DECODE, MEMADR and EXECUTE; the instruction register holds them stable after FETCH.
REQ-029 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.

Reset
REQ-030 rst high at a rising edge SHALL force state to RESET from any state, including mid-instruction, and all outputs SHALL read 0 while in RESET.
REQ-031 The first rising edge with rst low SHALL move the FSM from RESET to FETCH.

Structure
REQ-032 The following SHALL live in shared package mips_pkg: the state enum (4-bit, RESET=0, then the REQ-021 order), the opcode and funct constants, the alu_op typedef (2-bit), and the alu_control constants.
REQ-033 The alu_control decoding SHALL be a separate combinational sub-module, alu_decoder, with inputs alu_op and funct and output alu_control.

Verification
REQ-034 rst high for 2 cycles -> state=0 and all outputs 0; one cycle after release -> state=FETCH, ir_write=1, pc_en=1, alu_src_b=01, alu_control=010.
REQ-035 opcode 100011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_write=1 with mem_to_reg=1 and reg_dst=0 only in MEMWB.
REQ-036 opcode 000000 with funct 100010 -> EXECUTE shows alu_control=110; funct 101010 -> 111; ALUWB shows reg_write=1, reg_dst=1.
REQ-037 opcode 000100: zero=1 in BRANCH -> pc_en=1, pc_src=01; zero=0 -> pc_en=0; next state FETCH in both cases.
REQ-038 opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; reg_write and mem_write stay 0 throughout.
REQ-039 rst asserted while in MEMWRITE (opcode 101011) -> next cycle state=RESET, mem_write=0, then FETCH once rst is released.
